// File: rtl/toy_fetch_ctrl.sv
// Sequential instruction fetch with outstanding-request tracking, in-order decode FIFO,
// and stall/redirect handling driven by commit-stage change-of-flow signals.
//
// state | meaning
// RUN   | issuing sequential fetch requests
// HOLD  | control-flow inst fetched, waiting for commit to release
module toy_fetch_ctrl #(
  parameter int ADDR_WIDTH      = 32,
  parameter int INST_WIDTH      = 32,
  parameter int IBUF_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pc_release_en,
  input  logic                  pc_update_en,
  input  logic [ADDR_WIDTH-1:0] pc_val,
  input  logic                  pc_lock,
  output logic                  fetch_req_vld,
  input  logic                  fetch_req_rdy,
  output logic [ADDR_WIDTH-1:0] fetch_req_addr,
  input  logic                  fetch_ack_vld,
  input  logic [INST_WIDTH-1:0] fetch_ack_inst,
  output logic                  dec_vld,
  input  logic                  dec_rdy,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic [INST_WIDTH-1:0] dec_inst
);

  typedef enum logic [0:0] {RUN, HOLD} state_t;

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int IAW = $clog2(IBUF_DEPTH);
  localparam int QAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
  logic [OW-1:0]         outstanding, outstanding_nxt;
  logic [OW-1:0]         drop_cnt, drop_cnt_nxt;

  logic [ADDR_WIDTH-1:0] pcq [MAX_OUTSTANDING];
  logic [QAW-1:0]        pcq_wr, pcq_rd;

  logic [ADDR_WIDTH-1:0] ibuf_pc   [IBUF_DEPTH];
  logic [INST_WIDTH-1:0] ibuf_inst [IBUF_DEPTH];
  logic [IAW-1:0]        wr_ptr, rd_ptr;
  logic [IAW:0]          fifo_count;

  logic redirect, req_hs, push, pop, cf_push;
  logic [ADDR_WIDTH-1:0] ack_pc;

  function automatic logic is_cf(input logic [6:0] op);
    return (op == 7'b1101111) || (op == 7'b1100111) ||
           (op == 7'b1100011) || (op == 7'b1110011);
  endfunction

  function automatic logic [QAW-1:0] pcq_inc(input logic [QAW-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + QAW'(1);
  endfunction

  assign redirect       = pc_release_en & pc_update_en;
  assign fetch_req_vld  = (state == RUN) & ~pc_lock & ~redirect &
                          (int'(outstanding) < MAX_OUTSTANDING) &
                          (int'(outstanding) + int'(fifo_count) < IBUF_DEPTH);
  assign fetch_req_addr = fetch_pc;
  assign req_hs         = fetch_req_vld & fetch_req_rdy;
  assign ack_pc         = pcq[pcq_rd];
  assign push           = fetch_ack_vld & (drop_cnt == '0) & ~redirect;
  assign pop            = dec_vld & dec_rdy & ~redirect;
  assign cf_push        = push & is_cf(fetch_ack_inst[6:0]);

  assign outstanding_nxt = outstanding + OW'(req_hs) - OW'(fetch_ack_vld);

  assign dec_vld  = (fifo_count != '0);
  assign dec_pc   = dec_vld ? ibuf_pc[rd_ptr]   : '0;
  assign dec_inst = dec_vld ? ibuf_inst[rd_ptr] : '0;

  // Redirect overrides a same-cycle control-flow push; both count every fetch still in flight as stale.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    drop_cnt_nxt = drop_cnt;
    if (req_hs) fetch_pc_nxt = fetch_pc + ADDR_WIDTH'(4);
    if (fetch_ack_vld && (drop_cnt != '0)) drop_cnt_nxt = drop_cnt - OW'(1);
    if ((state == HOLD) && pc_release_en && !pc_update_en) state_nxt = RUN;
    if (cf_push) begin
      state_nxt    = HOLD;
      fetch_pc_nxt = ack_pc + ADDR_WIDTH'(4);
      drop_cnt_nxt = outstanding_nxt;
    end
    if (redirect) begin
      state_nxt    = RUN;
      fetch_pc_nxt = pc_val;
      drop_cnt_nxt = outstanding_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
      if (req_hs)        pcq_wr <= pcq_inc(pcq_wr);
      if (fetch_ack_vld) pcq_rd <= pcq_inc(pcq_rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + IAW'(1);
      if (pop)  rd_ptr <= rd_ptr + IAW'(1);
      fifo_count <= fifo_count + (IAW+1)'(push) - (IAW+1)'(pop);
    end
  end

  // Storage arrays need no reset: contents are only observed behind the pointers/count.
  always_ff @(posedge clk) begin
    if (req_hs) pcq[pcq_wr] <= fetch_pc;
    if (push) begin
      ibuf_pc[wr_ptr]   <= ack_pc;
      ibuf_inst[wr_ptr] <= fetch_ack_inst;
    end
  end

endmodule

// File: tb/tb_toy_fetch_ctrl.sv
// Bench for toy_fetch_ctrl: icache model with configurable latency, scoreboard of expected
// decode entries, a per-cycle request table for sequential fetch, and hand-written corner sequences.
module tb_toy_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_release_en, pc_update_en, pc_lock;
  logic [31:0] pc_val;
  logic        fetch_req_vld, fetch_req_rdy;
  logic [31:0] fetch_req_addr;
  logic        fetch_ack_vld;
  logic [31:0] fetch_ack_inst;
  logic        dec_vld, dec_rdy;
  logic [31:0] dec_pc, dec_inst;

  toy_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pc_release_en(pc_release_en), .pc_update_en(pc_update_en),
    .pc_val(pc_val), .pc_lock(pc_lock),
    .fetch_req_vld(fetch_req_vld), .fetch_req_rdy(fetch_req_rdy),
    .fetch_req_addr(fetch_req_addr),
    .fetch_ack_vld(fetch_ack_vld), .fetch_ack_inst(fetch_ack_inst),
    .dec_vld(dec_vld), .dec_rdy(dec_rdy), .dec_pc(dec_pc), .dec_inst(dec_inst)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int acc; bit keep;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} exp_t;
  typedef struct {logic rdy; logic drdy; logic exp_vld; logic [31:0] exp_addr;} vec_t;

  pend_t pend[$];
  exp_t  sb[$];
  vec_t  t1[9];

  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;
  int          lat    = 1;
  logic [31:0] cf_addr = 32'h0;
  logic [6:0]  cf_op   = 7'b1100011;

  logic        s_vld, s_dec_vld;
  logic [31:0] s_addr, s_dec_pc, s_dec_inst;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[24:0], (a == cf_addr) ? cf_op : 7'b0010011};
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // One clock cycle: icache ack, sample outputs, scoreboard update, advance to next negedge.
  task automatic cyc();
    pend_t a;
    exp_t  e;
    bit    ack_now = 0;
    bit    cf_now  = 0;
    bit    redir, hs;
    if (pend.size() > 0 && pend[0].acc + lat <= cyc_n) begin
      a = pend.pop_front();
      ack_now = 1;
      fetch_ack_vld  = 1'b1;
      fetch_ack_inst = inst_of(a.addr);
    end else begin
      fetch_ack_vld  = 1'b0;
      fetch_ack_inst = '0;
    end
    #1;
    redir      = pc_release_en && pc_update_en;
    s_vld      = fetch_req_vld;
    s_addr     = fetch_req_addr;
    s_dec_vld  = dec_vld;
    s_dec_pc   = dec_pc;
    s_dec_inst = dec_inst;
    hs         = fetch_req_vld && fetch_req_rdy;
    if (dec_vld && dec_rdy && !redir) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dec_extra: got pc %h with nothing expected", dec_pc);
      end else begin
        e = sb.pop_front();
        chk32("dec_pc", dec_pc, e.pc);
        chk32("dec_inst", dec_inst, e.inst);
      end
    end
    if (ack_now && a.keep && !redir) begin
      sb.push_back('{a.addr, inst_of(a.addr)});
      if (a.addr == cf_addr) cf_now = 1;
    end
    if (cf_now || redir) foreach (pend[i]) pend[i].keep = 0;
    if (redir) sb.delete();
    if (hs) pend.push_back('{fetch_req_addr, cyc_n, !(cf_now || redir)});
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    fetch_ack_vld = 1'b0; fetch_ack_inst = '0;
    pc_release_en = 1'b0; pc_update_en = 1'b0; pc_lock = 1'b0; pc_val = '0;
    fetch_req_rdy = 1'b0; dec_rdy = 1'b0;
    pend.delete();
    sb.delete();
    @(negedge clk);
    #1;
    chk1("rst_dec_vld", dec_vld, 1'b0);
    chk32("rst_req_addr", fetch_req_addr, 32'h8000_0000);
    chk32("rst_dec_pc", dec_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc_n = 0;
  endtask

  task automatic drain();
    fetch_req_rdy = 1'b0;
    dec_rdy = 1'b1;
    pc_release_en = 1'b0; pc_update_en = 1'b0; pc_lock = 1'b0;
    repeat (8) cyc();
    chk32("sb_empty", 32'(sb.size()), 32'h0);
    chk1("drain_dec_vld", s_dec_vld, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    pc_release_en = 1'b0; pc_update_en = 1'b0; pc_lock = 1'b0; pc_val = '0;
    fetch_req_rdy = 1'b0; fetch_ack_vld = 1'b0; fetch_ack_inst = '0; dec_rdy = 1'b0;

    // latency 2: two in flight blocks issue every third cycle
    t1[0] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000};
    t1[1] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004};
    t1[2] = '{1'b1, 1'b1, 1'b0, 32'h0};
    t1[3] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008};
    t1[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_000C};
    t1[5] = '{1'b1, 1'b1, 1'b0, 32'h0};
    t1[6] = '{1'b1, 1'b1, 1'b1, 32'h8000_0010};
    t1[7] = '{1'b1, 1'b1, 1'b1, 32'h8000_0014};
    t1[8] = '{1'b1, 1'b1, 1'b0, 32'h0};

    @(negedge clk);

    // T1 sequential fetch
    lat = 2; cf_addr = 32'h0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      fetch_req_rdy = t1[i].rdy;
      dec_rdy       = t1[i].drdy;
      cyc();
      chk1("t1_req_vld", s_vld, t1[i].exp_vld);
      if (t1[i].exp_vld) chk32("t1_req_addr", s_addr, t1[i].exp_addr);
    end
    drain();

    // T2 branch stalls, younger dropped, release continues at pc+4
    lat = 2; cf_addr = 32'h8000_0008; cf_op = 7'b1100011;
    do_reset();
    fetch_req_rdy = 1'b1; dec_rdy = 1'b1;
    repeat (12) cyc();
    chk1("t2_hold_vld", s_vld, 1'b0);
    pc_release_en = 1'b1;
    cyc();
    chk1("t2_rel_vld", s_vld, 1'b0);
    pc_release_en = 1'b0;
    cyc();
    chk1("t2_resume_vld", s_vld, 1'b1);
    chk32("t2_resume_addr", s_addr, 32'h8000_000C);
    repeat (6) cyc();
    drain();

    // T3 redirect from HOLD with an ack arriving the same cycle
    lat = 2; cf_addr = 32'h8000_0008; cf_op = 7'b1101111;
    do_reset();
    fetch_req_rdy = 1'b1; dec_rdy = 1'b0;
    repeat (6) cyc();
    chk1("t3_head_vld", s_dec_vld, 1'b1);
    chk32("t3_head_pc", s_dec_pc, 32'h8000_0000);
    pc_release_en = 1'b1; pc_update_en = 1'b1; pc_val = 32'h8000_0100;
    cyc();
    chk1("t3_redir_vld", s_vld, 1'b0);
    pc_release_en = 1'b0; pc_update_en = 1'b0; dec_rdy = 1'b1;
    cyc();
    chk1("t3_flushed", s_dec_vld, 1'b0);
    chk1("t3_new_vld", s_vld, 1'b1);
    chk32("t3_new_addr", s_addr, 32'h8000_0100);
    repeat (6) cyc();
    drain();

    // T4 decode backpressure fills FIFO, then drains in order
    lat = 1; cf_addr = 32'h0;
    do_reset();
    fetch_req_rdy = 1'b1; dec_rdy = 1'b0;
    repeat (10) cyc();
    chk1("t4_full_vld", s_vld, 1'b0);
    chk1("t4_dec_vld", s_dec_vld, 1'b1);
    chk32("t4_dec_pc", s_dec_pc, 32'h8000_0000);
    chk32("t4_dec_inst", s_dec_inst, inst_of(32'h8000_0000));
    dec_rdy = 1'b1;
    cyc();
    chk1("t4_still_full", s_vld, 1'b0);
    cyc();
    chk1("t4_resume_vld", s_vld, 1'b1);
    chk32("t4_resume_addr", s_addr, 32'h8000_0010);
    repeat (6) cyc();
    drain();

    // T5 pc_lock gates issue only; redirect at lock release
    lat = 2; cf_addr = 32'h0;
    do_reset();
    fetch_req_rdy = 1'b1; dec_rdy = 1'b1;
    repeat (2) cyc();
    pc_lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk1("t5_lock_vld", s_vld, 1'b0);
    end
    chk32("t5_acks_popped", 32'(sb.size()), 32'h0);
    pc_lock = 1'b0; pc_release_en = 1'b1; pc_update_en = 1'b1; pc_val = 32'h8000_0200;
    cyc();
    chk1("t5_redir_vld", s_vld, 1'b0);
    pc_release_en = 1'b0; pc_update_en = 1'b0;
    cyc();
    chk1("t5_new_vld", s_vld, 1'b1);
    chk32("t5_new_addr", s_addr, 32'h8000_0200);
    repeat (6) cyc();
    drain();

    // T6 redirect coinciding with ack and request attempt, then async reset mid-stream
    lat = 1; cf_addr = 32'h0;
    do_reset();
    fetch_req_rdy = 1'b1; dec_rdy = 1'b1;
    repeat (3) cyc();
    pc_release_en = 1'b1; pc_update_en = 1'b1; pc_val = 32'h8000_0300;
    cyc();
    chk1("t6_redir_vld", s_vld, 1'b0);
    pc_release_en = 1'b0; pc_update_en = 1'b0;
    cyc();
    chk1("t6_flushed", s_dec_vld, 1'b0);
    chk1("t6_new_vld", s_vld, 1'b1);
    chk32("t6_new_addr", s_addr, 32'h8000_0300);
    repeat (4) cyc();
    do_reset();
    fetch_req_rdy = 1'b1; dec_rdy = 1'b1;
    cyc();
    chk1("t6_post_rst_vld", s_vld, 1'b1);
    chk32("t6_post_rst_addr", s_addr, 32'h8000_0000);
    repeat (5) cyc();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
